pipe_out_fifo: RTL and testbench

PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

---
 rtl/pipe_out_fifo_if.sv | 31 +++
 rtl/pipe_out_fifo.sv | 78 +++++++
 tb/tb_pipe_out_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_out_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_out_fifo_if : push/pop bundle for the pipeline output FIFO | rev 1.0
// ---------------------------------------------------------------------------
interface pipe_out_fifo_if #(
  parameter int data_width = 16,
  parameter int id_width   = 3,
  parameter int cnt_width  = 3
);
  logic                  push_out_n;
  logic [id_width-1:0]   arrive_id;
  logic [data_width-1:0] data_in;
  logic                  accept_n;
  logic                  out_valid;
  logic                  out_ready;
  logic [id_width-1:0]   out_id;
  logic [data_width-1:0] out_data;
  logic [cnt_width-1:0]  fifo_count;
  logic                  ovf;

  modport master (
    output push_out_n, arrive_id, data_in, out_ready,
    input  accept_n, out_valid, out_id, out_data, fifo_count, ovf
  );

  modport slave (
    input  push_out_n, arrive_id, data_in, out_ready,
    output accept_n, out_valid, out_id, out_data, fifo_count, ovf
  );
endinterface
`default_nettype wire

// File: rtl/pipe_out_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_out_fifo : show-ahead circular FIFO for {id, data} pipeline results | rev 1.0
// ---------------------------------------------------------------------------
module pipe_out_fifo #(
  parameter int data_width = 16,
  parameter int id_width   = 3,
  parameter int depth      = 4,
  parameter int cnt_width  = 3
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  pipe_out_fifo_if.slave      bus
);
  localparam int ptr_width   = $clog2(depth);
  localparam int entry_width = id_width + data_width;

  logic [entry_width-1:0] mem [depth];
  logic [ptr_width-1:0]   wr_ptr;
  logic [ptr_width-1:0]   rd_ptr;
  logic [cnt_width-1:0]   count;
  logic [cnt_width-1:0]   next_count;
  logic                   ovf_flag;
  logic                   full;
  logic                   pop;
  logic                   push_ok;
  logic [entry_width-1:0] head;

  function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
    return (p == ptr_width'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full is decoded from the count register only, so accept_n has no path
  // from out_ready or push_out_n; a push at full is still taken if a pop frees a slot.
  assign full    = (count == cnt_width'(depth));
  assign pop     = (count != '0) && bus.out_ready;
  assign push_ok = !bus.push_out_n && (!full || pop);

  always_comb begin
    next_count = count;
    if (push_ok && !pop)
      next_count = count + 1'b1;
    else if (!push_ok && pop)
      next_count = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      count <= next_count;
      if (push_ok)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      if (!bus.push_out_n && !push_ok)
        ovf_flag <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok)
      mem[wr_ptr] <= {bus.arrive_id, bus.data_in};
  end

  assign head           = mem[rd_ptr];
  assign bus.out_id     = head[entry_width-1:data_width];
  assign bus.out_data   = head[data_width-1:0];
  assign bus.out_valid  = (count != '0);
  assign bus.accept_n   = full;
  assign bus.fifo_count = count;
  assign bus.ovf        = ovf_flag;
endmodule
`default_nettype wire

// File: tb/tb_pipe_out_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_out_fifo : directed vector table plus randomized run against a queue model | rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_out_fifo;
  localparam int DW = 16;
  localparam int IW = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pipe_out_fifo_if #(.data_width(DW), .id_width(IW), .cnt_width(3)) bif ();

  pipe_out_fifo #(.data_width(DW), .id_width(IW), .depth(DEPTH), .cnt_width(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } entry_t;

  // Reference model: an ordered queue of stored entries plus a sticky flag.
  entry_t q[$];
  bit     m_ovf   = 1'b0;
  bit     m_known = 1'b0;

  typedef struct {
    bit            push;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    bit            rdy;
    bit            rn;
    int            cnt;
    bit            v;
    bit            an;
    bit            ov;
    logic [IW-1:0] eid;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    if (!m_known) return;
    chk("model_count", 32'(bif.fifo_count), 32'(q.size()));
    chk("model_valid", 32'(bif.out_valid), 32'(q.size() != 0));
    chk("model_accept_n", 32'(bif.accept_n), 32'(q.size() == DEPTH));
    chk("model_ovf", 32'(bif.ovf), 32'(m_ovf));
    if (q.size() != 0) begin
      chk("model_head_id", 32'(bif.out_id), 32'(q[0].id));
      chk("model_head_data", 32'(bif.out_data), 32'(q[0].data));
    end
  endtask

  task automatic model_step(input bit push, input logic [IW-1:0] id, input logic [DW-1:0] d,
                            input bit rdy, input bit rn);
    bit popping;
    if (!rn) begin
      q.delete();
      m_ovf   = 1'b0;
      m_known = 1'b1;
      return;
    end
    popping = (q.size() != 0) && rdy;
    if (popping) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back('{id: id, data: d});
      else m_ovf = 1'b1;
    end
  endtask

  // Inputs change on the falling edge; state is checked mid-low-phase
  // (before the rising edge) and again 1 time unit after it.
  task automatic cycle(input bit push, input logic [IW-1:0] id, input logic [DW-1:0] d,
                       input bit rdy, input bit rn);
    @(negedge clk);
    bif.push_out_n = !push;
    bif.arrive_id  = id;
    bif.data_in    = d;
    bif.out_ready  = rdy;
    rst_n          = rn;
    #1;
    check_model();
    model_step(push, id, d, rdy, rn);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.push_out_n = 1'b1;
    bif.arrive_id  = '0;
    bif.data_in    = '0;
    bif.out_ready  = 1'b0;
    rst_n          = 1'b0;

    //           push id  data     rdy rn  cnt v an ov eid data
    tbl[0]  = '{0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000};
    tbl[1]  = '{1, 3'd0, 16'h0011, 0, 1, 1, 1, 0, 0, 3'd0, 16'h0011};
    tbl[2]  = '{1, 3'd1, 16'h0022, 0, 1, 2, 1, 0, 0, 3'd0, 16'h0011};
    tbl[3]  = '{1, 3'd2, 16'h0033, 0, 1, 3, 1, 0, 0, 3'd0, 16'h0011};
    tbl[4]  = '{1, 3'd3, 16'h0044, 0, 1, 4, 1, 1, 0, 3'd0, 16'h0011};
    tbl[5]  = '{0, 3'd0, 16'h0000, 0, 1, 4, 1, 1, 0, 3'd0, 16'h0011};
    tbl[6]  = '{1, 3'd5, 16'h0055, 1, 1, 4, 1, 1, 0, 3'd1, 16'h0022};
    tbl[7]  = '{1, 3'd6, 16'h0066, 0, 1, 4, 1, 1, 1, 3'd1, 16'h0022};
    tbl[8]  = '{0, 3'd0, 16'h0000, 0, 1, 4, 1, 1, 1, 3'd1, 16'h0022};
    tbl[9]  = '{0, 3'd0, 16'h0000, 1, 1, 3, 1, 0, 1, 3'd2, 16'h0033};
    tbl[10] = '{0, 3'd0, 16'h0000, 1, 1, 2, 1, 0, 1, 3'd3, 16'h0044};
    tbl[11] = '{0, 3'd0, 16'h0000, 1, 1, 1, 1, 0, 1, 3'd5, 16'h0055};
    tbl[12] = '{0, 3'd0, 16'h0000, 1, 1, 0, 0, 0, 1, 3'd0, 16'h0000};
    tbl[13] = '{0, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0000};
    tbl[14] = '{1, 3'd7, 16'h0077, 1, 1, 1, 1, 0, 0, 3'd7, 16'h0077};
    tbl[15] = '{0, 3'd0, 16'h0000, 1, 1, 0, 0, 0, 0, 3'd0, 16'h0000};
    tbl[16] = '{1, 3'd1, 16'h0101, 0, 1, 1, 1, 0, 0, 3'd1, 16'h0101};
    tbl[17] = '{1, 3'd2, 16'h0202, 0, 1, 2, 1, 0, 0, 3'd1, 16'h0101};
    tbl[18] = '{1, 3'd3, 16'h0303, 1, 0, 0, 0, 0, 0, 3'd0, 16'h0000};

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].push, tbl[i].id, tbl[i].data, tbl[i].rdy, tbl[i].rn);
      chk($sformatf("vec%0d_count", i), 32'(bif.fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_valid", i), 32'(bif.out_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_accept_n", i), 32'(bif.accept_n), 32'(tbl[i].an));
      chk($sformatf("vec%0d_ovf", i), 32'(bif.ovf), 32'(tbl[i].ov));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_id", i), 32'(bif.out_id), 32'(tbl[i].eid));
        chk($sformatf("vec%0d_data", i), 32'(bif.out_data), 32'(tbl[i].ed));
      end
    end

    // Wrap-around: hold two entries, then push and pop together for 10 cycles.
    cycle(0, 3'd0, 16'h0, 0, 0);
    cycle(1, 3'd0, 16'hA000, 0, 1);
    cycle(1, 3'd1, 16'hA001, 0, 1);
    for (int k = 2; k < 12; k++) begin
      cycle(1, IW'(k % 8), 16'hA000 + 16'(k), 1, 1);
      chk("wrap_count_const", 32'(bif.fifo_count), 32'd2);
    end
    // Fill to full, then push+pop at full keeps count at depth.
    cycle(1, 3'd4, 16'hB004, 0, 1);
    cycle(1, 3'd5, 16'hB005, 0, 1);
    cycle(1, 3'd6, 16'hB006, 1, 1);
    chk("full_pushpop_count", 32'(bif.fifo_count), 32'd4);
    chk("full_pushpop_ovf", 32'(bif.ovf), 32'd0);
    // Count=1 with push+pop stays 1.
    cycle(0, 3'd0, 16'h0, 0, 0);
    cycle(1, 3'd2, 16'hC002, 0, 1);
    cycle(1, 3'd3, 16'hC003, 1, 1);
    chk("one_pushpop_count", 32'(bif.fifo_count), 32'd1);
    chk("one_pushpop_head", 32'(bif.out_data), 32'hC003);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 99) < 60), IW'($urandom), 16'($urandom),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) != 0));
    end
    @(negedge clk);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
